arc_mem_port: RTL

Memory access port between the ARC control unit/datapath and `main_memory`. It accepts one word load or store request at a time over a req/ready handshake and latches the address and write data. It drives the memory's `rd`/`wr` strobes and absorbs the memory's one-cycle registered read latency plus optional wait states. It returns read data and flags misaligned word addresses without touching memory.

---
 rtl/arc_mem_pkg.sv | 22 ++
 rtl/arc_mem_wait_cnt.sv | 26 ++
 rtl/arc_mem_port.sv | 139 +++++++++++++
 3 files changed

// File: rtl/arc_mem_pkg.sv
// arc_mem_pkg: shared types and constants for the ARC memory access port.
package arc_mem_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        WAIT = 3'd3,
        CAP  = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } memState_t;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
    localparam int         MAX_WAIT        = 15;

    // A word access is legal only when the low byte-offset bits are clear.
    function automatic logic isMisaligned(input logic [1:0] lowBits);
        return (lowBits & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/arc_mem_wait_cnt.sv
// arc_mem_wait_cnt: 4-bit loadable down-counter that times memory wait states.
module arc_mem_wait_cnt (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [3:0] i_loadValue,
    input  logic       i_en,
    output logic       o_zero
);

    logic [3:0] r_count;

    // Load takes priority; counting stops at zero so o_zero stays asserted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (i_en && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/arc_mem_port.sv
// arc_mem_port: single-outstanding word load/store port in front of main_memory.
module arc_mem_port
    import arc_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_err,
    output logic        o_busy,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_data_in,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    input  logic [31:0] i_mem_data_out
);

    // Wait-state count is clamped to what the 4-bit counter can express.
    localparam int         WaitEff  = (WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT :
                                      (WAIT_CYCLES < 0) ? 0 : WAIT_CYCLES;
    localparam logic [3:0] WaitLoad = 4'((WaitEff > 0) ? (WaitEff - 1) : 0);

    memState_t   r_state;
    memState_t   w_nextState;
    logic        w_accept;
    logic        w_cntLoad;
    logic        w_cntEn;
    logic        w_cntZero;
    logic        w_capture;
    logic        r_isLoad;
    logic [31:0] r_memAddress;
    logic [31:0] r_memDataIn;
    logic [31:0] r_rdata;

    arc_mem_wait_cnt u_waitCnt (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (w_cntLoad),
        .i_loadValue (WaitLoad),
        .i_en        (w_cntEn),
        .o_zero      (w_cntZero)
    );

    // State register; reset aborts any access in flight without a completion pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode plus the one-cycle control strobes for the datapath and counter.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_cntLoad   = 1'b0;
        w_cntEn     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req) begin
                    w_accept = 1'b1;
                    if (isMisaligned(i_addr[1:0])) begin
                        w_nextState = ERR;
                    end else if (i_we) begin
                        w_nextState = WR;
                    end else begin
                        w_nextState = RD;
                    end
                end
            end
            RD: begin
                if (WaitEff > 0) begin
                    w_nextState = WAIT;
                    w_cntLoad   = 1'b1;
                end else begin
                    w_nextState = CAP;
                end
            end
            WR: begin
                if (WaitEff > 0) begin
                    w_nextState = WAIT;
                    w_cntLoad   = 1'b1;
                end else begin
                    w_nextState = DONE;
                end
            end
            WAIT: begin
                w_cntEn = 1'b1;
                if (w_cntZero) begin
                    w_nextState = r_isLoad ? CAP : DONE;
                end
            end
            CAP: begin
                w_capture   = 1'b1;
                w_nextState = DONE;
            end
            DONE:    w_nextState = IDLE;
            ERR:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Request latch and load-result register; address/data hold until the next accepted request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_memAddress <= 32'd0;
            r_memDataIn  <= 32'd0;
            r_isLoad     <= 1'b0;
            r_rdata      <= 32'd0;
        end else begin
            if (w_accept) begin
                r_memAddress <= i_addr;
                r_memDataIn  <= i_wdata;
                r_isLoad     <= ~i_we;
            end
            if (w_capture) begin
                r_rdata <= i_mem_data_out;
            end
        end
    end

    assign o_mem_rd      = (r_state == RD);
    assign o_mem_wr      = (r_state == WR);
    assign o_ready       = (r_state == DONE) || (r_state == ERR);
    assign o_err         = (r_state == ERR);
    assign o_busy        = (r_state != IDLE);
    assign o_mem_address = r_memAddress;
    assign o_mem_data_in = r_memDataIn;
    assign o_rdata       = r_rdata;

endmodule
